// File: rtl/cfu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cfu_arbiter
//  Description : Shares one CFU datapath between two command sources.
//                Round-robin grant, registered command, CFU handshake
//                sequencing, result capture and return to the issuing
//                requester only. At most one transaction is outstanding
//                because the CFU carries no transaction ID.
//
//  Ports
//    clk, reset_n                      clock, async active-low reset
//    m{0,1}_cmd_valid / _ready         requester command handshake
//    m{0,1}_cmd_payload_function_id    3-bit CFU function select
//    m{0,1}_cmd_payload_inputs_{0,1}   32-bit operands
//    m{0,1}_rsp_valid / _ready         requester response handshake
//    m{0,1}_rsp_payload_outputs_0      32-bit result (shared register)
//    cfu_cmd_valid / _ready            command to the shared CFU
//    cfu_cmd_payload_*                 registered command payload
//    cfu_rsp_valid / _ready            CFU response handshake
//    cfu_rsp_payload_outputs_0         CFU result
//
//  Revision    : 1.0  initial release
// ============================================================================
module cfu_arbiter (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_cmd_valid,
    output logic        m0_cmd_ready,
    input  logic [2:0]  m0_cmd_payload_function_id,
    input  logic [31:0] m0_cmd_payload_inputs_0,
    input  logic [31:0] m0_cmd_payload_inputs_1,
    output logic        m0_rsp_valid,
    input  logic        m0_rsp_ready,
    output logic [31:0] m0_rsp_payload_outputs_0,

    input  logic        m1_cmd_valid,
    output logic        m1_cmd_ready,
    input  logic [2:0]  m1_cmd_payload_function_id,
    input  logic [31:0] m1_cmd_payload_inputs_0,
    input  logic [31:0] m1_cmd_payload_inputs_1,
    output logic        m1_rsp_valid,
    input  logic        m1_rsp_ready,
    output logic [31:0] m1_rsp_payload_outputs_0,

    output logic        cfu_cmd_valid,
    input  logic        cfu_cmd_ready,
    output logic [2:0]  cfu_cmd_payload_function_id,
    output logic [31:0] cfu_cmd_payload_inputs_0,
    output logic [31:0] cfu_cmd_payload_inputs_1,
    input  logic        cfu_rsp_valid,
    output logic        cfu_rsp_ready,
    input  logic [31:0] cfu_rsp_payload_outputs_0
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_last_grant;   // 1: m1 was granted last, 0: m0
    logic        r_owner;        // requester that owns the outstanding command
    logic        r_cmd_done;
    logic        r_rsp_done;
    logic [2:0]  r_fid;
    logic [31:0] r_in0;
    logic [31:0] r_in1;
    logic [31:0] r_result;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_cmd_fire;
    logic        w_cmd_seen;
    logic        w_rsp_fire;
    logic        w_issue_done;
    logic        w_owner_rsp_ready;

    // Round-robin grant. Gated by reset_n so no ready is presented to a
    // requester while the block is held in reset.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (reset_n && (r_state == ST_IDLE)) begin
            if (m0_cmd_valid && m1_cmd_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = ~r_last_grant;
            end else begin
                w_grant0 = m0_cmd_valid;
                w_grant1 = m1_cmd_valid;
            end
        end
    end

    assign w_accept          = w_grant0 | w_grant1;
    assign w_cmd_fire        = cfu_cmd_valid & cfu_cmd_ready;
    // A CFU response only counts once the command has been handed over,
    // either earlier or in this very cycle.
    assign w_cmd_seen        = r_cmd_done | w_cmd_fire;
    assign w_rsp_fire        = cfu_rsp_valid & cfu_rsp_ready & w_cmd_seen & ~r_rsp_done;
    assign w_issue_done      = w_cmd_seen & (r_rsp_done | w_rsp_fire);
    assign w_owner_rsp_ready = r_owner ? m1_rsp_ready : m0_rsp_ready;

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cmd_done   <= 1'b0;
            r_rsp_done   <= 1'b0;
            r_fid        <= 3'd0;
            r_in0        <= 32'd0;
            r_in1        <= 32'd0;
            r_result     <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_owner      <= w_grant1;
                r_last_grant <= w_grant1;
                r_fid        <= w_grant1 ? m1_cmd_payload_function_id : m0_cmd_payload_function_id;
                r_in0        <= w_grant1 ? m1_cmd_payload_inputs_0    : m0_cmd_payload_inputs_0;
                r_in1        <= w_grant1 ? m1_cmd_payload_inputs_1    : m0_cmd_payload_inputs_1;
                r_cmd_done   <= 1'b0;
                r_rsp_done   <= 1'b0;
            end
            if (w_cmd_fire) begin
                r_cmd_done <= 1'b1;
            end
            if (w_rsp_fire) begin
                r_rsp_done <= 1'b1;
                r_result   <= cfu_rsp_payload_outputs_0;
            end
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_next  = r_state;
        cfu_cmd_valid = 1'b0;
        cfu_rsp_ready = 1'b0;
        m0_rsp_valid  = 1'b0;
        m1_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cfu_cmd_valid = ~r_cmd_done;
                cfu_rsp_ready = 1'b1;
                if (w_issue_done) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                m0_rsp_valid = ~r_owner;
                m1_rsp_valid = r_owner;
                if (w_owner_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign m0_cmd_ready                = w_grant0;
    assign m1_cmd_ready                = w_grant1;
    assign m0_rsp_payload_outputs_0    = r_result;
    assign m1_rsp_payload_outputs_0    = r_result;
    assign cfu_cmd_payload_function_id = r_fid;
    assign cfu_cmd_payload_inputs_0    = r_in0;
    assign cfu_cmd_payload_inputs_1    = r_in1;

endmodule
`default_nettype wire

// File: doc/cfu_arbiter.md
# cfu_arbiter

Two-requester arbiter that shares a single CFU datapath instance (byte-sum / byte-swap / bit-reverse, selected by `function_id`) between two command sources, e.g. the CPU CFU port and a second master. It sits between the two requesters and the CFU. It grants one command at a time by round-robin, registers the command, sequences the CFU handshake, captures the result and returns it only to the requester that issued it. The CFU carries no transaction ID, so at most one transaction is outstanding.

## Interface
- No parameters; data width fixed at 32, function_id width fixed at 3.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `m0_cmd_valid` / `m1_cmd_valid` in 1: requester command valid.
- `m0_cmd_ready` / `m1_cmd_ready` out 1: command accepted this cycle.
- `m0_cmd_payload_function_id` / `m1_…` in 3: CFU function select.
- `m0_cmd_payload_inputs_0` / `_1`, `m1_…` in 32 each: operands.
- `m0_rsp_valid` / `m1_rsp_valid` out 1: result valid to that requester.
- `m0_rsp_ready` / `m1_rsp_ready` in 1: requester accepts result.
- `m0_rsp_payload_outputs_0` / `m1_…` out 32: result; both driven from one result register.
- `cfu_cmd_valid` out 1; `cfu_cmd_ready` in 1: command to the shared CFU.
- `cfu_cmd_payload_function_id` out 3; `cfu_cmd_payload_inputs_0` / `_1` out 32: registered command.
- `cfu_rsp_valid` in 1; `cfu_rsp_ready` out 1; `cfu_rsp_payload_outputs_0` in 32: CFU response.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If one requester has `cmd_valid`, grant it.
  - If both do, grant the one not granted last. `last_grant` resets to 1, so m0 wins the first tie.
  - The granted requester's `cmd_ready` = 1 combinationally in the same cycle; the other's is 0.
  - On the handshake, register function_id, inputs_0, inputs_1 and the owner ID. Update `last_grant`. Go to ISSUE.
- ISSUE:
  - `cfu_cmd_valid` = 1 until `cfu_cmd_ready`; payload stays stable while waiting.
  - `cfu_rsp_ready` = 1 for the whole state.
  - Sticky flags `cmd_done` and `rsp_done` are cleared on entry.
  - `cmd_done` sets on `cfu_cmd_valid && cfu_cmd_ready`; `cfu_cmd_valid` drops after that.
  - `rsp_done` sets on `cfu_rsp_valid && cfu_rsp_ready`, but only in the cmd handshake cycle or later. Earlier `cfu_rsp_valid` is ignored.
  - On the `rsp_done` event, capture `cfu_rsp_payload_outputs_0` into the result register.
  - Both events may occur in the same cycle (combinational CFU: `rsp_valid` = `cmd_valid`, `cmd_ready` = `rsp_ready`).
  - Go to RESP once both flags are set, counting that cycle's events.
- RESP:
  - Owner's `rsp_valid` = 1; the non-owner's `rsp_valid` = 0.
  - Hold until the owner's `rsp_ready`, then go to IDLE.
  - No new command is accepted in RESP.
- Requesters that are not granted keep `cmd_valid` asserted; there is no loss and no starvation. With continuous contention, grants alternate m0, m1, m0, ….
- Result register is overwritten only at capture; its value persists after RESP.

## Timing
- Reset (async assert) values:
  - state = IDLE, `last_grant` = 1, flags = 0.
  - All `*_valid` and `*_ready` outputs = 0.
  - `cfu_cmd_payload_*` = 0, result register = 0.
- Reset asserted mid-transaction aborts it. The pending command and result are discarded; no `rsp_valid` is produced after reset release.
- Best case with a combinational CFU:
  - Cycle 0: upstream cmd handshake (IDLE).
  - Cycle 1: CFU cmd+rsp handshake (ISSUE).
  - Cycle 2: owner `rsp_valid` (RESP), handshake if ready.
  - Cycle 3: IDLE, may accept the next command.
  - Throughput is one transaction per 3 cycles.
- A multi-cycle CFU adds one cycle per cycle of `cfu_cmd_ready` / `cfu_rsp_valid` delay.
- Owner `rsp_valid`, once asserted, stays high with a stable payload until `rsp_ready`.
- Upstream `cmd_ready` is combinational from `cmd_valid` and state. All other outputs are registered or decoded from state.

## Test plan
- Single m0 command (fid=0, in0=0x01020304, in1=0x10203040) into combinational CFU -> m0_cmd_ready in cycle 0, cfu_cmd_valid in cycle 1, m0_rsp_valid in cycle 2 with 0x000000AA; m1_rsp_valid stays 0.
- Both requesters valid every cycle, m1 fid=1 in0=0x11223344, m0 fid=2 in0=0x00000001, rsp_ready=1 -> grants m0, m1, m0, m1; m1 receives 0x44332211, m0 receives 0x80000000, each on its own port only.
- CFU with cfu_cmd_ready delayed 3 cycles and rsp 2 cycles after that -> cfu_cmd payload stable while waiting; result returned to owner; no extra cmd accepted meanwhile.
- Owner holds rsp_ready=0 for 5 cycles while the other requester is valid -> rsp_valid/payload stable; other requester is not granted until the cycle after the rsp handshake.
- reset_n pulsed low during ISSUE -> all valids/readys 0 immediately; after release, no response appears; next tie grants m0.
- cfu_rsp_valid asserted before cfu_cmd_ready -> ignored; the result is captured from the response at or after the cmd handshake.
